// File: rtl/fsm_core_pkg.sv
// -----------------------------------------------------------------------------
// fsm_core_pkg: FSM state encodings and pool defaults shared by the scheduler
// and the FPUs.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package fsm_core_pkg;

  localparam int DEF_NUM_PROC = 16;
  localparam int DEF_ID_W     = 4;
  localparam int DEF_MAX_FORK = 4;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ARB   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_ALLOC = 3'd4;
  localparam logic [2:0] ST_GRANT = 3'd5;

  // Child counts above the per-grant limit are clipped, not rejected.
  function automatic logic [3:0] sat_need(input logic [3:0] cnt, input logic [3:0] max_fork);
    return (cnt > max_fork) ? max_fork : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pid_free_fifo.sv
// -----------------------------------------------------------------------------
// pid_free_fifo: free process-ID FIFO with push/pop, occupancy and init port.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pid_free_fifo #(
  parameter int NUM_PROC = 16,
  parameter int ID_W     = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            init_we_i,
  input  logic [ID_W-1:0] init_addr_i,
  input  logic [ID_W-1:0] init_data_i,
  input  logic            init_fill_i,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_data_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] pop_data_o,
  output logic [ID_W:0]   count_o,
  output logic            full_o
);

  logic [ID_W-1:0] mem_q [NUM_PROC];
  logic [ID_W-1:0] head_q, head_d;
  logic [ID_W-1:0] tail_q, tail_d;
  logic [ID_W:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o     = (count_q == (ID_W+1)'(NUM_PROC));
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && (count_q != '0);
  assign pop_data_o = mem_q[head_q];
  assign count_o    = count_q;

  // Pointers wrap on their own; count_q alone tells full from empty.
  always_comb begin
    head_d  = head_q + ID_W'(pop_ok);
    tail_d  = tail_q + ID_W'(push_ok);
    count_d = count_q + (ID_W+1)'(push_ok) - (ID_W+1)'(pop_ok);
    if (init_fill_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = (ID_W+1)'(NUM_PROC);
    end
  end

  always_ff @(posedge clk) begin
    if (init_we_i) begin
      mem_q[init_addr_i] <= init_data_i;
    end else if (push_ok) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fork_scheduler.sv
// -----------------------------------------------------------------------------
// fork_scheduler: round-robin fork arbiter and process-ID allocator.
// Optional FORK_SCHED_STATS_EN adds grant / hold-cycle counters.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fork_scheduler
  import fsm_core_pkg::*;
#(
  parameter int NUM_FPU  = 4,
  parameter int NUM_PROC = DEF_NUM_PROC,
  parameter int ID_W     = DEF_ID_W,
  parameter int MAX_FORK = DEF_MAX_FORK
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_FPU-1:0]       fork_req,
  input  logic [NUM_FPU*4-1:0]     fork_count,
  output logic [NUM_FPU-1:0]       fork_grant,
  output logic [MAX_FORK*ID_W-1:0] grant_ids,
  output logic [3:0]               grant_count,
  input  logic                     release_valid,
  input  logic [ID_W-1:0]          release_id,
  output logic                     init_done,
  output logic [ID_W:0]            free_count,
  output logic                     err_overflow,
  output logic                     busy
`ifdef FORK_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_grants,
  output logic [31:0]              stat_hold_cycles
`endif
);

  localparam int SEL_W = (NUM_FPU > 1) ? $clog2(NUM_FPU) : 1;

  logic [2:0]               state_q, state_d;
  logic [SEL_W-1:0]         rr_q, rr_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [3:0]               need_q, need_d;
  logic [3:0]               k_q, k_d;
  logic [ID_W-1:0]          init_cnt_q, init_cnt_d;
  logic [MAX_FORK*ID_W-1:0] ids_q, ids_d;
  logic                     init_done_q, init_done_d;
  logic                     err_q, err_d;
  logic                     busy_q;

  logic                     arb_found;
  logic [SEL_W-1:0]         arb_sel;
  logic [3:0]               arb_cnt;
  logic [3:0]               arb_need;
  logic                     hi_found;
  logic [SEL_W-1:0]         hi_sel;

  logic                     fifo_init_we;
  logic                     fifo_init_fill;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic [ID_W-1:0]          fifo_pop_data;
  logic [ID_W:0]            fifo_count;

  pid_free_fifo #(
    .NUM_PROC (NUM_PROC),
    .ID_W     (ID_W)
  ) u_free_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .init_we_i   (fifo_init_we),
    .init_addr_i (init_cnt_q),
    .init_data_i (init_cnt_q),
    .init_fill_i (fifo_init_fill),
    .push_i      (fifo_push),
    .push_data_i (release_id),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_pop_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

  assign fifo_push = release_valid && (state_q != ST_INIT);
  assign err_d     = err_q | (fifo_push & fifo_full);

  // Lowest requester at/above rr_q wins; otherwise wrap to the lowest overall.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    hi_found  = 1'b0;
    hi_sel    = '0;
    arb_cnt   = '0;
    for (int j = NUM_FPU - 1; j >= 0; j--) begin
      if (fork_req[j]) begin
        arb_found = 1'b1;
        arb_sel   = SEL_W'(j);
        if (j >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_sel   = SEL_W'(j);
        end
      end
    end
    if (hi_found) arb_sel = hi_sel;
    for (int j = 0; j < NUM_FPU; j++) begin
      if (arb_sel == SEL_W'(j)) arb_cnt = fork_count[j*4 +: 4];
    end
    arb_need = sat_need(arb_cnt, 4'(MAX_FORK));
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    sel_d          = sel_q;
    need_d         = need_q;
    k_d            = k_q;
    init_cnt_d     = init_cnt_q;
    ids_d          = ids_q;
    init_done_d    = init_done_q;
    fifo_init_we   = 1'b0;
    fifo_init_fill = 1'b0;
    fifo_pop       = 1'b0;
    case (state_q)
      ST_INIT: begin
        fifo_init_we = 1'b1;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == ID_W'(NUM_PROC - 1)) begin
          fifo_init_fill = 1'b1;
          init_done_d    = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (|fork_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        ids_d = '0;
        k_d   = '0;
        if (!arb_found) begin
          state_d = ST_IDLE;
        end else begin
          sel_d  = arb_sel;
          need_d = arb_need;
          if (arb_need == 4'd0)                          state_d = ST_GRANT;
          else if (int'(arb_need) <= int'(fifo_count))   state_d = ST_ALLOC;
          else                                           state_d = ST_HOLD;
        end
      end
      // The selected requester keeps its claim so large forks cannot starve.
      ST_HOLD: begin
        if (!fork_req[sel_q])                         state_d = ST_IDLE;
        else if (int'(need_q) <= int'(fifo_count))    state_d = ST_ALLOC;
      end
      ST_ALLOC: begin
        fifo_pop = 1'b1;
        for (int k = 0; k < MAX_FORK; k++) begin
          if (k_q == 4'(k)) ids_d[k*ID_W +: ID_W] = fifo_pop_data;
        end
        k_d = k_q + 4'd1;
        if (k_q + 4'd1 == need_q) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        rr_d    = SEL_W'((int'(sel_q) + 1) % NUM_FPU);
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      rr_q        <= '0;
      sel_q       <= '0;
      need_q      <= '0;
      k_q         <= '0;
      init_cnt_q  <= '0;
      ids_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      sel_q       <= sel_d;
      need_q      <= need_d;
      k_q         <= k_d;
      init_cnt_q  <= init_cnt_d;
      ids_q       <= ids_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    fork_grant = '0;
    if (state_q == ST_GRANT) fork_grant[sel_q] = 1'b1;
  end

  assign grant_ids    = (state_q == ST_GRANT) ? ids_q : '0;
  assign grant_count  = (state_q == ST_GRANT) ? need_q : 4'd0;
  assign init_done    = init_done_q;
  assign free_count   = fifo_count;
  assign err_overflow = err_q;
  assign busy         = busy_q;

`ifdef FORK_SCHED_STATS_EN
  logic [31:0] stat_grants_q;
  logic [31:0] stat_hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grants_q <= '0;
      stat_hold_q   <= '0;
    end else begin
      if (state_q == ST_GRANT && stat_grants_q != '1) stat_grants_q <= stat_grants_q + 32'd1;
      if (state_q == ST_HOLD && stat_hold_q != '1)    stat_hold_q   <= stat_hold_q + 32'd1;
    end
  end

  assign stat_grants      = stat_grants_q;
  assign stat_hold_cycles = stat_hold_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fork_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fork_scheduler: self-checking bench for fork_scheduler.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fork_scheduler;

  logic        clk;
  logic        reset_n;
  logic [3:0]  fork_req;
  logic [15:0] fork_count;
  logic [3:0]  fork_grant;
  logic [15:0] grant_ids;
  logic [3:0]  grant_count;
  logic        release_valid;
  logic [3:0]  release_id;
  logic        init_done;
  logic [4:0]  free_count;
  logic        err_overflow;
  logic        busy;
`ifdef FORK_SCHED_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_hold_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: free list as an ordered queue, IDs handed out, rr pointer.
  int fq[$];
  int alloc[$];
  int rr_m = 0;
  bit err_m = 0;

  fork_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fork_req      (fork_req),
    .fork_count    (fork_count),
    .fork_grant    (fork_grant),
    .grant_ids     (grant_ids),
    .grant_count   (grant_count),
    .release_valid (release_valid),
    .release_id    (release_id),
    .init_done     (init_done),
    .free_count    (free_count),
    .err_overflow  (err_overflow),
    .busy          (busy)
`ifdef FORK_SCHED_STATS_EN
    ,
    .stat_grants      (stat_grants),
    .stat_hold_cycles (stat_hold_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int arb_model(input logic [3:0] req);
    for (int i = 0; i < 4; i++) begin
      int idx = (rr_m + i) % 4;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_count(input int fpu, input int cnt);
    fork_count = (fork_count & ~(16'hF << (fpu * 4))) | (16'(cnt & 15) << (fpu * 4));
  endtask

  task automatic check_grant(input int sel, input int cnt);
    int need;
    need = (cnt > 4) ? 4 : cnt;
    check("grant_onehot", {28'd0, fork_grant}, 32'(1) << sel);
    check("grant_count", {28'd0, grant_count}, need);
    for (int k = 0; k < 4; k++) begin
      int exp;
      exp = 0;
      if (k < need && fq.size() > 0) begin
        exp = fq.pop_front();
        alloc.push_back(exp);
      end
      check("grant_id", {28'd0, grant_ids[k*4 +: 4]}, exp);
    end
    check("free_at_grant", {27'd0, free_count}, fq.size());
    rr_m = (sel + 1) % 4;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (fork_grant == 4'b0 && lat < 200);
    if (fork_grant == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant after %0d cycles expected a grant", lat);
    end
  endtask

  task automatic drive_release(input int id);
    int found;
    release_valid = 1'b1;
    release_id    = 4'(id);
    if (fq.size() < 16) fq.push_back(id);
    else err_m = 1'b1;
    found = -1;
    for (int i = 0; i < alloc.size(); i++) begin
      if (found < 0 && alloc[i] == id) found = i;
    end
    if (found >= 0) alloc.delete(found);
    @(negedge clk);
    release_valid = 1'b0;
  endtask

  task automatic do_fork(input int fpu, input int cnt, output int lat);
    fork_req = fork_req | (4'b1 << fpu);
    set_count(fpu, cnt);
    wait_grant(lat);
    check_grant(arb_model(fork_req), cnt);
    fork_req = fork_req & ~(4'b1 << fpu);
  endtask

  typedef struct {
    int         fpu;
    int         cnt;
    logic [3:0] exp_grant;
    int         exp_gc;
    int         exp_lat;
  } vec_t;

  initial begin
    vec_t       tbl[4];
    int         lat;
    int         n;
    int         fc_before;
    int         rid;
    int         alt_seq[4];
    logic [3:0] pend;
    int         pend_cnt[4];
    int         grants;
    int         cyc;

    tbl[0] = '{1, 2, 4'b0010, 2, 4};
    tbl[1] = '{3, 9, 4'b1000, 4, 6};
    tbl[2] = '{0, 0, 4'b0001, 0, 2};
    tbl[3] = '{2, 1, 4'b0100, 1, 3};
    alt_seq = '{0, 2, 0, 2};

    reset_n       = 1'b0;
    fork_req      = '0;
    fork_count    = '0;
    release_valid = 1'b0;
    release_id    = '0;
    repeat (3) @(negedge clk);
    check("rst_init_done", {31'd0, init_done}, 0);
    check("rst_free", {27'd0, free_count}, 0);
    check("rst_grant", {28'd0, fork_grant}, 0);
    check("rst_gcount", {28'd0, grant_count}, 0);
    check("rst_ids", {16'd0, grant_ids}, 0);
    check("rst_err", {31'd0, err_overflow}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    // Releases during INIT must be ignored.
    reset_n       = 1'b1;
    release_valid = 1'b1;
    release_id    = 4'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) release_valid = 1'b0;
    end while (!init_done && n < 100);
    check("init_cycles", n, 16);
    check("init_free", {27'd0, free_count}, 16);
    check("init_err", {31'd0, err_overflow}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 16; i++) fq.push_back(i);

    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      do_fork(tbl[r].fpu, tbl[r].cnt, lat);
      check("vec_latency", lat, tbl[r].exp_lat);
      check("vec_grant", {28'd0, fork_grant}, {28'd0, tbl[r].exp_grant});
      check("vec_gcount", {28'd0, grant_count}, tbl[r].exp_gc);
    end

    // FPU0 and FPU2 hold requests continuously; grants must alternate.
    @(negedge clk);
    set_count(0, 1);
    set_count(2, 1);
    fork_req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_grant(lat);
      check("alt_grant", {28'd0, fork_grant}, 32'(1) << alt_seq[g]);
      check_grant(arb_model(fork_req), 1);
    end
    fork_req = '0;

    // Drain to one free ID, then a 3-child fork must wait for two releases.
    @(negedge clk);
    do_fork(1, 4, lat);
    check("drained_free", {27'd0, free_count}, 1);
    fork_req = 4'b1000;
    set_count(3, 3);
    repeat (6) @(negedge clk);
    check("hold_no_grant", {28'd0, fork_grant}, 0);
    check("hold_busy", {31'd0, busy}, 1);
    drive_release(5);
    check("hold_one_release", {28'd0, fork_grant}, 0);
    drive_release(7);
    wait_grant(lat);
    check("hold_ids", {16'd0, grant_ids}, 32'h075F);
    check_grant(3, 3);
    fork_req = '0;

    // Refill the pool, then overflow it.
    while (alloc.size() > 0) drive_release(alloc[0]);
    check("refill_free", {27'd0, free_count}, 16);
    check("refill_err", {31'd0, err_overflow}, 0);
    drive_release(3);
    check("ovf_err", {31'd0, err_overflow}, 1);
    check("ovf_free", {27'd0, free_count}, 16);
    repeat (3) @(negedge clk);
    check("ovf_sticky", {31'd0, err_overflow}, {31'd0, err_m});

    // Release coincides with the first ALLOC pop; count 9 saturates to 4.
    @(negedge clk);
    do_fork(0, 2, lat);
    @(negedge clk);
    fork_req = 4'b0100;
    set_count(2, 9);
    @(negedge clk);
    @(negedge clk);
    fc_before = int'(free_count);
    check("overlap_pre_free", fc_before, fq.size());
    rid = alloc[0];
    drive_release(rid);
    check("overlap_free", {27'd0, free_count}, fc_before);
    wait_grant(lat);
    check("overlap_rest_lat", lat, 3);
    check_grant(2, 9);
    fork_req = '0;

    // Randomized traffic against the queue model.
    pend = 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) begin
      pend_cnt[i] = $urandom_range(0, 9);
      set_count(i, pend_cnt[i]);
    end
    fork_req = pend;
    grants = 0;
    cyc = 0;
    while (grants < 40 && cyc < 6000) begin
      int s;
      @(negedge clk);
      cyc++;
      release_valid = 1'b0;
      if (fork_grant != 4'b0) begin
        s = arb_model(pend);
        if (s < 0) s = 0;
        check_grant(s, pend_cnt[s]);
        grants++;
        pend = pend & ~(4'b1 << s);
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            pend_cnt[i] = $urandom_range(0, 9);
            set_count(i, pend_cnt[i]);
          end
        end
        if (pend == 4'b0) begin
          s = $urandom_range(0, 3);
          pend[s] = 1'b1;
          pend_cnt[s] = $urandom_range(0, 9);
          set_count(s, pend_cnt[s]);
        end
        fork_req = pend;
      end
      if (alloc.size() > 0 && $urandom_range(0, 2) == 0) begin
        int idx;
        int id;
        idx = $urandom_range(0, alloc.size() - 1);
        id  = alloc[idx];
        alloc.delete(idx);
        release_valid = 1'b1;
        release_id    = 4'(id);
        if (fq.size() < 16) fq.push_back(id);
        else err_m = 1'b1;
      end
    end
    fork_req = '0;
    release_valid = 1'b0;
    check("random_grants", grants, 40);
    @(negedge clk);
    while (alloc.size() > 0) drive_release(alloc[0]);
    check("final_free", {27'd0, free_count}, fq.size());
    check("final_err", {31'd0, err_overflow}, {31'd0, err_m});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
